// File: rtl/write_buffer_p.sv
// Write buffer: FWFT queue with per-byte parity, occupancy flags
// and sticky overflow/underflow indicators.
module write_buffer_p #(
    parameter int    WIDTH     = 144,
    parameter int    DEPTH     = 512,
    parameter int    AF_OFFSET = 128,
    parameter string PARITY    = "TRUE"
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Flush,
    input  logic [WIDTH-1:0]         WD,
    input  logic                     WRen,
    input  logic                     InjErr,
    output logic                     Full,
    output logic                     AlmostFull,
    output logic [WIDTH-1:0]         MD,
    input  logic                     RDen,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     PErr,
    output logic                     Ovf,
    output logic                     Udf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int NB  = WIDTH / 8;
    localparam bit PEN = (PARITY == "TRUE");

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr, rptr_n1;
    logic [CW-1:0]    cnt, cnt_n;
    logic             rdy;
    logic             full_q, empty_q, af_q, ovf_q, udf_q;
    logic [WIDTH-1:0] md_q;
    logic             wr_acc, rd_acc;
    logic             md_load, md_from_wd;

    assign wr_acc  = rdy & WRen & ~full_q & ~Flush;
    assign rd_acc  = rdy & RDen & ~empty_q & ~Flush;
    assign rptr_n1 = rptr + AW'(1);

    // Head register reloads when a word lands in an empty queue or the
    // head is popped; with one entry left the new head comes from WD.
    assign md_from_wd = empty_q | (cnt == CW'(1));
    assign md_load    = (wr_acc & empty_q)
                      | (rd_acc & (wr_acc | (cnt != CW'(1))));

    // Next occupancy from accepted write/read, cleared by flush
    always_comb begin
        cnt_n = cnt;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_n = cnt + CW'(1);
            2'b01:   cnt_n = cnt - CW'(1);
            default: cnt_n = cnt;
        endcase
        if (Flush) cnt_n = '0;
    end

    // Data storage, not reset; flush only makes entries unreachable
    always_ff @(posedge Clk) begin
        if (wr_acc) mem[wptr] <= WD;
    end

    // Control state, flags and head-of-queue register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rdy     <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            md_q    <= '0;
        end else begin
            rdy <= 1'b1;
            if (Flush) begin
                wptr  <= '0;
                rptr  <= '0;
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                if (wr_acc) wptr <= wptr + AW'(1);
                if (rd_acc) rptr <= rptr_n1;
                if (rdy & WRen & full_q)  ovf_q <= 1'b1;
                if (rdy & RDen & empty_q) udf_q <= 1'b1;
            end
            cnt     <= cnt_n;
            full_q  <= (cnt_n == CW'(DEPTH));
            empty_q <= (cnt_n == '0);
            af_q    <= (cnt_n >= CW'(DEPTH - AF_OFFSET));
            if (md_load) md_q <= md_from_wd ? WD : mem[rptr_n1];
        end
    end

    assign Full       = full_q;
    assign AlmostFull = af_q;
    assign Empty      = empty_q;
    assign Count      = cnt;
    assign Ovf        = ovf_q;
    assign Udf        = udf_q;
    assign MD         = md_q;

    if (PEN) begin : g_par
        logic [NB-1:0] pmem [DEPTH];
        logic [NB-1:0] par_in, md_par, md_chk;

        // Even parity per byte; InjErr corrupts byte 0
        always_comb begin
            par_in = '0;
            md_chk = '0;
            for (int i = 0; i < NB; i++) begin
                par_in[i] = ^WD[8*i +: 8];
                md_chk[i] = ^md_q[8*i +: 8];
            end
            par_in[0] = par_in[0] ^ InjErr;
        end

        // Parity storage alongside the data array
        always_ff @(posedge Clk) begin
            if (wr_acc) pmem[wptr] <= par_in;
        end

        // Parity of the head word, loaded in step with MD
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) md_par <= '0;
            else if (md_load)
                md_par <= md_from_wd ? par_in : pmem[rptr_n1];
        end

        assign PErr = ~empty_q & (|(md_chk ^ md_par));
    end else begin : g_nopar
        logic unused_injerr;
        assign unused_injerr = InjErr;
        assign PErr = 1'b0;
    end

endmodule

// File: tb/tb_write_buffer_p.sv
// Directed bench for write_buffer_p (WIDTH=8, DEPTH=4, AF_OFFSET=1),
// plus a PARITY="FALSE" instance sharing the same stimulus.
module tb_write_buffer_p;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] wd = '0;
    logic       wren = 1'b0;
    logic       injerr = 1'b0;
    logic       rden = 1'b0;
    logic       full, af, empty, perr, ovf, udf;
    logic [7:0] md;
    logic [2:0] cnt;
    logic       full_f, af_f, empty_f, perr_f, ovf_f, udf_f;
    logic [7:0] md_f;
    logic [2:0] cnt_f;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    write_buffer_p #(.WIDTH(8), .DEPTH(4), .AF_OFFSET(1), .PARITY("TRUE")) dut (
        .Clk(clk), .Reset_n(rst_n), .Flush(flush), .WD(wd), .WRen(wren),
        .InjErr(injerr), .Full(full), .AlmostFull(af), .MD(md), .RDen(rden),
        .Empty(empty), .Count(cnt), .PErr(perr), .Ovf(ovf), .Udf(udf)
    );

    write_buffer_p #(.WIDTH(8), .DEPTH(4), .AF_OFFSET(1), .PARITY("FALSE")) dut_np (
        .Clk(clk), .Reset_n(rst_n), .Flush(flush), .WD(wd), .WRen(wren),
        .InjErr(injerr), .Full(full_f), .AlmostFull(af_f), .MD(md_f), .RDen(rden),
        .Empty(empty_f), .Count(cnt_f), .PErr(perr_f), .Ovf(ovf_f), .Udf(udf_f)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        nchk++; if (empty !== 1'b1) begin nfail++; $display("FAIL rst_empty: got %b want 1", empty); end
        nchk++; if (cnt !== 3'd0) begin nfail++; $display("FAIL rst_count: got %0d want 0", cnt); end
        nchk++; if (full !== 1'b0 || af !== 1'b0) begin nfail++; $display("FAIL rst_full_af: got %b%b want 00", full, af); end
        nchk++; if (ovf !== 1'b0 || udf !== 1'b0) begin nfail++; $display("FAIL rst_ovf_udf: got %b%b want 00", ovf, udf); end
        nchk++; if (md !== 8'h00 || perr !== 1'b0) begin nfail++; $display("FAIL rst_md_perr: got %h/%b want 00/0", md, perr); end
        @(negedge clk);
        rst_n = 1'b1;
        wd = 8'h77; wren = 1'b1;
        tick;
        nchk++; if (cnt !== 3'd0) begin nfail++; $display("FAIL rst_sync_edge1: got %0d want 0", cnt); end
        tick;
        nchk++; if (cnt !== 3'd1 || md !== 8'h77) begin nfail++; $display("FAIL rst_sync_edge2: got %0d/%h want 1/77", cnt, md); end
        wren = 1'b0; flush = 1'b1;
        tick;
        flush = 1'b0;
        nchk++; if (empty !== 1'b1 || cnt !== 3'd0) begin nfail++; $display("FAIL rst_flush: got %b/%0d want 1/0", empty, cnt); end
    endtask

    task automatic test_basic;
        wd = 8'h11; wren = 1'b1;
        tick;
        nchk++; if (empty !== 1'b0 || md !== 8'h11) begin nfail++; $display("FAIL fwft_first: got %b/%h want 0/11", empty, md); end
        wd = 8'h22;
        tick;
        wren = 1'b0;
        nchk++; if (cnt !== 3'd2 || md !== 8'h11) begin nfail++; $display("FAIL basic_two: got %0d/%h want 2/11", cnt, md); end
        rden = 1'b1;
        tick;
        nchk++; if (cnt !== 3'd1 || md !== 8'h22) begin nfail++; $display("FAIL basic_pop: got %0d/%h want 1/22", cnt, md); end
        tick;
        rden = 1'b0;
        nchk++; if (cnt !== 3'd0 || empty !== 1'b1) begin nfail++; $display("FAIL basic_drain: got %0d/%b want 0/1", cnt, empty); end
    endtask

    task automatic test_full;
        wren = 1'b1;
        wd = 8'h01; tick;
        wd = 8'h02; tick;
        nchk++; if (af !== 1'b0) begin nfail++; $display("FAIL af_at2: got %b want 0", af); end
        wd = 8'h03; tick;
        nchk++; if (af !== 1'b1 || full !== 1'b0) begin nfail++; $display("FAIL af_at3: got %b/%b want 1/0", af, full); end
        wd = 8'h04; tick;
        nchk++; if (full !== 1'b1 || cnt !== 3'd4) begin nfail++; $display("FAIL full_at4: got %b/%0d want 1/4", full, cnt); end
        wd = 8'h05; tick;
        nchk++; if (ovf !== 1'b1 || cnt !== 3'd4 || md !== 8'h01) begin nfail++; $display("FAIL ovf_set: got %b/%0d/%h want 1/4/01", ovf, cnt, md); end
        wd = 8'h06; rden = 1'b1; tick;
        wren = 1'b0;
        nchk++; if (cnt !== 3'd3 || md !== 8'h02 || full !== 1'b0) begin nfail++; $display("FAIL full_rw: got %0d/%h/%b want 3/02/0", cnt, md, full); end
        tick;
        nchk++; if (md !== 8'h03) begin nfail++; $display("FAIL drain_3: got %h want 03", md); end
        tick;
        nchk++; if (md !== 8'h04 || cnt !== 3'd1) begin nfail++; $display("FAIL drain_4: got %h/%0d want 04/1", md, cnt); end
        tick;
        rden = 1'b0;
        nchk++; if (empty !== 1'b1 || ovf !== 1'b1 || udf !== 1'b0) begin nfail++; $display("FAIL drain_end: got %b/%b/%b want 1/1/0", empty, ovf, udf); end
        flush = 1'b1; tick; flush = 1'b0;
        nchk++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_udf;
        wd = 8'h3C; wren = 1'b1; rden = 1'b1;
        tick;
        wren = 1'b0;
        nchk++; if (udf !== 1'b1 || cnt !== 3'd1 || md !== 8'h3C) begin nfail++; $display("FAIL udf_rw: got %b/%0d/%h want 1/1/3c", udf, cnt, md); end
        tick;
        rden = 1'b0;
        nchk++; if (empty !== 1'b1 || udf !== 1'b1) begin nfail++; $display("FAIL udf_sticky: got %b/%b want 1/1", empty, udf); end
        flush = 1'b1; tick; flush = 1'b0;
        nchk++; if (udf !== 1'b0) begin nfail++; $display("FAIL udf_clear: got %b want 0", udf); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        logic [7:0] v;
        int maxc = 0;
        for (int i = 0; i < 12; i++) begin
            v = 8'(8'h30 + 7 * i);
            wd = v; wren = 1'b1; rden = (i >= 2);
            tick;
            q.push_back(v);
            if (i >= 2) void'(q.pop_front());
            if (int'(cnt) > maxc) maxc = int'(cnt);
            nchk++; if (md !== q[0] || int'(cnt) != q.size()) begin nfail++; $display("FAIL b2b_%0d: got %h/%0d want %h/%0d", i, md, cnt, q[0], q.size()); end
        end
        wren = 1'b0; rden = 1'b1;
        tick;
        void'(q.pop_front());
        nchk++; if (md !== q[0] || cnt !== 3'd1) begin nfail++; $display("FAIL b2b_tail: got %h/%0d want %h/1", md, cnt, q[0]); end
        tick;
        rden = 1'b0;
        nchk++; if (empty !== 1'b1 || maxc > 2) begin nfail++; $display("FAIL b2b_end: got %b/max%0d want 1/max<=2", empty, maxc); end
        nchk++; if (ovf !== 1'b0 || udf !== 1'b0) begin nfail++; $display("FAIL b2b_flags: got %b%b want 00", ovf, udf); end
    endtask

    task automatic test_parity;
        wd = 8'hA5; wren = 1'b1; injerr = 1'b1;
        tick;
        wd = 8'h5A; injerr = 1'b0;
        tick;
        wren = 1'b0;
        nchk++; if (md !== 8'hA5 || perr !== 1'b1) begin nfail++; $display("FAIL par_inj: got %h/%b want a5/1", md, perr); end
        nchk++; if (perr_f !== 1'b0 || md_f !== 8'hA5) begin nfail++; $display("FAIL par_off_inj: got %b/%h want 0/a5", perr_f, md_f); end
        rden = 1'b1;
        tick;
        nchk++; if (md !== 8'h5A || perr !== 1'b0) begin nfail++; $display("FAIL par_clean: got %h/%b want 5a/0", md, perr); end
        tick;
        rden = 1'b0;
        nchk++; if (empty !== 1'b1 || perr !== 1'b0) begin nfail++; $display("FAIL par_empty: got %b/%b want 1/0", empty, perr); end
    endtask

    task automatic test_flush_reset;
        wren = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wd = 8'(8'h41 + i);
            tick;
        end
        wren = 1'b0; rden = 1'b1;
        tick;
        rden = 1'b0;
        nchk++; if (cnt !== 3'd3 || ovf !== 1'b1 || md !== 8'h42) begin nfail++; $display("FAIL fl_setup: got %0d/%b/%h want 3/1/42", cnt, ovf, md); end
        flush = 1'b1; wren = 1'b1; wd = 8'hEE;
        tick;
        flush = 1'b0; wren = 1'b0;
        nchk++; if (cnt !== 3'd0 || empty !== 1'b1 || ovf !== 1'b0) begin nfail++; $display("FAIL fl_clear: got %0d/%b/%b want 0/1/0", cnt, empty, ovf); end
        nchk++; if (full !== 1'b0 || af !== 1'b0) begin nfail++; $display("FAIL fl_flags: got %b%b want 00", full, af); end
        wd = 8'h99; wren = 1'b1;
        tick;
        wd = 8'h98;
        tick;
        wren = 1'b0;
        nchk++; if (cnt !== 3'd2 || md !== 8'h99) begin nfail++; $display("FAIL fl_nowrite: got %0d/%h want 2/99", cnt, md); end
        #2;
        rst_n = 1'b0;
        #1;
        nchk++; if (cnt !== 3'd0 || empty !== 1'b1 || md !== 8'h00) begin nfail++; $display("FAIL async_rst: got %0d/%b/%h want 0/1/00", cnt, empty, md); end
        nchk++; if (full !== 1'b0 || af !== 1'b0 || perr !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0) begin nfail++; $display("FAIL async_rst_flags: got %b%b%b%b%b want 00000", full, af, perr, ovf, udf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_udf;
        test_back_to_back;
        test_parity;
        test_flush_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
